// File: rtl/win_pkg.sv
// rtl/win_pkg.sv - shared types and window index mapping for the 3x3 window generator
package win_pkg;

  localparam int DEF_PIX_W = 8;
  localparam int WIN_N     = 9;
  localparam int WIN_DIM   = 3;

  typedef logic [DEF_PIX_W-1:0] pix_t;

  // Row-major window: element 0 is pix1 (top-left, oldest), element 8 is pix9 (newest)
  typedef pix_t [WIN_N-1:0] win_t;

  localparam int IDX_CENTRE = 4;

  function automatic int win_idx(input int row, input int col);
    return row * WIN_DIM + col;
  endfunction

endpackage

// File: rtl/win_gen_3x3_line_buf.sv
// rtl/win_gen_3x3_line_buf.sv - single-port line buffer, async read, sync write
module line_buf #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Combinational read returns the old word in the same cycle as the write
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/win_gen_3x3.sv
// rtl/win_gen_3x3.sv - raster stream to 3x3 neighbourhood window generator
module win_gen_3x3 #(
  parameter int PIX_W = win_pkg::DEF_PIX_W,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic [PIX_W-1:0] in_pix,
  output logic [PIX_W-1:0] pix1,
  output logic [PIX_W-1:0] pix2,
  output logic [PIX_W-1:0] pix3,
  output logic [PIX_W-1:0] pix4,
  output logic [PIX_W-1:0] pix5,
  output logic [PIX_W-1:0] pix6,
  output logic [PIX_W-1:0] pix7,
  output logic [PIX_W-1:0] pix8,
  output logic [PIX_W-1:0] pix9,
  output logic             win_valid,
  output logic             win_sol,
  output logic             win_eof
);

  import win_pkg::*;

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_TWO  = CW'(2);
  localparam logic [RW-1:0] ROW_TWO  = RW'(2);

  logic [CW-1:0]    col_q, col_cur, col_nxt;
  logic [RW-1:0]    row_q, row_cur, row_nxt;
  logic [PIX_W-1:0] rd_top, rd_mid;
  logic [PIX_W-1:0] win_q [WIN_N];
  logic [PIX_W-1:0] new_col [WIN_DIM];
  logic             win_hit, sol_hit, eof_hit;
  logic             win_valid_q, win_sol_q, win_eof_q;

  // A start-of-frame pixel is (0,0) whatever the counters say
  always_comb begin
    col_cur = in_sof ? '0 : col_q;
    row_cur = in_sof ? '0 : row_q;
  end

  always_comb begin
    col_nxt = col_cur + CW'(1);
    row_nxt = row_cur;
    if (col_cur == COL_LAST) begin
      col_nxt = '0;
      row_nxt = (row_cur == ROW_LAST) ? '0 : row_cur + RW'(1);
    end
  end

  always_comb begin
    win_hit = (row_cur >= ROW_TWO) && (col_cur >= COL_TWO);
    sol_hit = win_hit && (col_cur == COL_TWO);
    eof_hit = win_hit && (row_cur == ROW_LAST) && (col_cur == COL_LAST);
  end

  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_top (
    .clk   (clk),
    .we    (in_valid),
    .addr  (col_cur),
    .wdata (rd_mid),
    .rdata (rd_top)
  );

  line_buf #(.DEPTH(IMG_W), .WIDTH(PIX_W)) u_lb_mid (
    .clk   (clk),
    .we    (in_valid),
    .addr  (col_cur),
    .wdata (in_pix),
    .rdata (rd_mid)
  );

  // Column entering the right edge of the window, top to bottom
  always_comb begin
    new_col[0] = rd_top;
    new_col[1] = rd_mid;
    new_col[2] = in_pix;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
      for (int i = 0; i < WIN_N; i++) begin
        win_q[i] <= '0;
      end
    end else begin
      win_valid_q <= 1'b0;
      win_sol_q   <= 1'b0;
      win_eof_q   <= 1'b0;
      if (in_valid) begin
        col_q       <= col_nxt;
        row_q       <= row_nxt;
        win_valid_q <= win_hit;
        win_sol_q   <= sol_hit;
        win_eof_q   <= eof_hit;
        for (int r = 0; r < WIN_DIM; r++) begin
          win_q[win_idx(r, 0)] <= win_q[win_idx(r, 1)];
          win_q[win_idx(r, 1)] <= win_q[win_idx(r, 2)];
          win_q[win_idx(r, 2)] <= new_col[r];
        end
      end
    end
  end

  assign pix1      = win_q[0];
  assign pix2      = win_q[1];
  assign pix3      = win_q[2];
  assign pix4      = win_q[3];
  assign pix5      = win_q[IDX_CENTRE];
  assign pix6      = win_q[5];
  assign pix7      = win_q[6];
  assign pix8      = win_q[7];
  assign pix9      = win_q[8];
  assign win_valid = win_valid_q;
  assign win_sol   = win_sol_q;
  assign win_eof   = win_eof_q;

endmodule

// File: tb/tb_win_gen_3x3.sv
// tb/tb_win_gen_3x3.sv - self-checking bench for win_gen_3x3 (4x4 and 8x5 instances)
module tb_win_gen_3x3;

  typedef struct {
    logic [7:0] p [9];
    logic       sol;
    logic       eof;
  } win_s;

  typedef struct {
    logic [7:0] pix;
    logic       sof;
    logic       v;
    logic       sol;
    logic       eof;
    logic [7:0] p1;
    logic [7:0] p5;
    logic [7:0] p9;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid [2];
  logic       in_sof   [2];
  logic [7:0] in_pix   [2];
  logic [7:0] wp       [2][9];
  logic       wv [2];
  logic       ws [2];
  logic       we [2];

  always #5 clk = ~clk;

  win_gen_3x3 #(.PIX_W(8), .IMG_W(4), .IMG_H(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_sof(in_sof[0]), .in_pix(in_pix[0]),
    .pix1(wp[0][0]), .pix2(wp[0][1]), .pix3(wp[0][2]), .pix4(wp[0][3]), .pix5(wp[0][4]),
    .pix6(wp[0][5]), .pix7(wp[0][6]), .pix8(wp[0][7]), .pix9(wp[0][8]),
    .win_valid(wv[0]), .win_sol(ws[0]), .win_eof(we[0])
  );

  win_gen_3x3 #(.PIX_W(8), .IMG_W(8), .IMG_H(5)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_sof(in_sof[1]), .in_pix(in_pix[1]),
    .pix1(wp[1][0]), .pix2(wp[1][1]), .pix3(wp[1][2]), .pix4(wp[1][3]), .pix5(wp[1][4]),
    .pix6(wp[1][5]), .pix7(wp[1][6]), .pix8(wp[1][7]), .pix9(wp[1][8]),
    .win_valid(wv[1]), .win_sol(ws[1]), .win_eof(we[1])
  );

  int         total = 0;
  int         bad   = 0;
  int         pulses;
  int         eofs;
  int         mrow [2];
  int         mcol [2];
  int         imgw [2] = '{4, 8};
  int         imgh [2] = '{4, 5};
  logic [7:0] img  [2][5][8];
  logic [7:0] held [2][9];
  win_s       q0 [$];
  win_s       q1 [$];
  vec_t       vt [16];

  task automatic cmp(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference frame store: the expected window is cut straight from the image
  task automatic model_push(input int s, input logic sof, input logic [7:0] pix);
    int   r, c;
    win_s w;
    if (sof) begin
      mrow[s] = 0;
      mcol[s] = 0;
    end
    r = mrow[s];
    c = mcol[s];
    img[s][r][c] = pix;
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          w.p[i*3+j] = img[s][r-2+i][c-2+j];
      w.sol = (c == 2);
      w.eof = (r == imgh[s] - 1) && (c == imgw[s] - 1);
      if (s == 0) q0.push_back(w);
      else        q1.push_back(w);
    end
    if (c == imgw[s] - 1) begin
      mcol[s] = 0;
      mrow[s] = (r == imgh[s] - 1) ? 0 : r + 1;
    end else begin
      mcol[s] = c + 1;
    end
  endtask

  task automatic check(input int s, input bit acc);
    win_s w;
    int   qn;
    qn = (s == 0) ? q0.size() : q1.size();
    if (wv[s]) begin
      if (qn == 0) begin
        cmp("unexpected_window", 1, 0);
      end else begin
        w = (s == 0) ? q0.pop_front() : q1.pop_front();
        for (int i = 0; i < 9; i++)
          cmp($sformatf("pix%0d", i + 1), int'(wp[s][i]), int'(w.p[i]));
        cmp("win_sol", int'(ws[s]), int'(w.sol));
        cmp("win_eof", int'(we[s]), int'(w.eof));
        pulses++;
        if (we[s]) eofs++;
      end
    end else begin
      if (qn != 0) begin
        cmp("missing_window", 0, 1);
        if (s == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
      end
      cmp("sol_without_valid", int'(ws[s]), 0);
      cmp("eof_without_valid", int'(we[s]), 0);
    end
    if (!acc) begin
      for (int i = 0; i < 9; i++)
        cmp($sformatf("hold_pix%0d", i + 1), int'(wp[s][i]), int'(held[s][i]));
    end
    for (int i = 0; i < 9; i++) held[s][i] = wp[s][i];
  endtask

  task automatic step(input int s, input bit v, input bit sof, input logic [7:0] pix);
    in_valid[s] = v;
    in_sof[s]   = sof;
    in_pix[s]   = pix;
    if (v) model_push(s, sof, pix);
    @(posedge clk);
    #1;
    check(s, v);
    in_valid[s] = 1'b0;
    in_sof[s]   = 1'b0;
  endtask

  task automatic frame(input int s, input bit sof_first, input bit gaps, input logic [7:0] xorv);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        step(s, 1'b1, sof_first && r == 0 && c == 0, 8'(16 * r + c) ^ xorv);
        if (gaps) step(s, 1'b0, 1'b0, 8'h5a);
      end
  endtask

  task automatic start_test();
    pulses = 0;
    eofs   = 0;
    step(0, 1'b0, 1'b0, 8'h00);
    step(1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic check_all_zero(input string tag);
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 9; i++) cmp($sformatf("%s_pix%0d", tag, i + 1), int'(wp[s][i]), 0);
      cmp({tag, "_valid"}, int'(wv[s]), 0);
      cmp({tag, "_sol"}, int'(ws[s]), 0);
      cmp({tag, "_eof"}, int'(we[s]), 0);
      for (int i = 0; i < 9; i++) held[s][i] = wp[s][i];
      mrow[s] = 0;
      mcol[s] = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      vt[i] = '{8'(16 * (i / 4) + i % 4), i == 0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
    vt[10] = '{8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h11, 8'h22};
    vt[11] = '{8'h23, 1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'h12, 8'h23};
    vt[14] = '{8'h32, 1'b0, 1'b1, 1'b1, 1'b0, 8'h10, 8'h21, 8'h32};
    vt[15] = '{8'h33, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22, 8'h33};

    rst_n = 1'b0;
    for (int s = 0; s < 2; s++) begin
      in_valid[s] = 1'b0;
      in_sof[s]   = 1'b0;
      in_pix[s]   = 8'h00;
    end
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ramp frame, continuous, from the vector table
    start_test();
    for (int i = 0; i < 16; i++) begin
      step(0, 1'b1, vt[i].sof, vt[i].pix);
      cmp($sformatf("tbl%0d_valid", i), int'(wv[0]), int'(vt[i].v));
      cmp($sformatf("tbl%0d_sol", i), int'(ws[0]), int'(vt[i].sol));
      cmp($sformatf("tbl%0d_eof", i), int'(we[0]), int'(vt[i].eof));
      if (vt[i].v) begin
        cmp($sformatf("tbl%0d_pix1", i), int'(wp[0][0]), int'(vt[i].p1));
        cmp($sformatf("tbl%0d_pix5", i), int'(wp[0][4]), int'(vt[i].p5));
        cmp($sformatf("tbl%0d_pix9", i), int'(wp[0][8]), int'(vt[i].p9));
      end
    end
    cmp("ramp_pulses", pulses, 4);
    cmp("ramp_eofs", eofs, 1);

    // Same frame with idle cycles between accepts
    start_test();
    frame(0, 1'b1, 1'b1, 8'h00);
    cmp("gap_pulses", pulses, 4);

    // Back-to-back frames, second relies on the row wrap and carries different data
    start_test();
    frame(0, 1'b1, 1'b0, 8'h00);
    frame(0, 1'b0, 1'b0, 8'h80);
    cmp("b2b_pulses", pulses, 8);
    cmp("b2b_eofs", eofs, 2);

    // Reset after pixel 0x21, then a full frame with no in_sof
    start_test();
    for (int i = 0; i < 10; i++) step(0, 1'b1, i == 0, 8'(16 * (i / 4) + i % 4));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("midrst");
    rst_n = 1'b1;
    pulses = 0;
    frame(0, 1'b0, 1'b0, 8'h00);
    cmp("midrst_pulses", pulses, 4);

    // in_sof at pixel (2,1) restarts the frame
    start_test();
    for (int i = 0; i < 9; i++) step(0, 1'b1, i == 0, 8'(16 * (i / 4) + i % 4));
    step(0, 1'b1, 1'b1, 8'h00);
    cmp("sof_no_window", int'(wv[0]), 0);
    for (int i = 1; i < 16; i++) step(0, 1'b1, 1'b0, 8'(16 * (i / 4) + i % 4));
    cmp("sof_restart_pulses", pulses, 4);

    // 8x5 instance with random pixels
    start_test();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 8; c++)
        step(1, 1'b1, r == 0 && c == 0, 8'($urandom_range(0, 255)));
    step(1, 1'b0, 1'b0, 8'h00);
    cmp("rand_pulses", pulses, 18);
    cmp("rand_eofs", eofs, 1);
    cmp("queue_a_drained", q0.size(), 0);
    cmp("queue_b_drained", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/win_gen_3x3.md
Name: win_gen_3x3

Overview:
- Raster-stream to 3x3 window generator; the producer side of the 3x3 median filter's nine-pixel window interface.
- Accepts one pixel per valid cycle in raster order, buffers two previous lines, and presents complete 3x3 neighbourhoods as pix1..pix9 with a window-valid strobe.
- Sits between the video/pixel source and the median filter.

Parameters:
- PIX_W, 8, pixel bit width
- IMG_W, 640, active pixels per line (≥3)
- IMG_H, 480, active lines per frame (≥3)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  in_pix is valid this cycle
- in_sof  in  1  qualifies in_valid; this pixel is (row 0, col 0)
- in_pix  in  PIX_W  raster pixel
- pix1..pix9  out  PIX_W each  window, row-major: pix1..pix3 top line (oldest), pix4..pix6 middle, pix7..pix9 bottom (newest); pix9 = most recent pixel, pix5 = centre
- win_valid  out  1  pix1..pix9 form a complete in-image window
- win_sol  out  1  with win_valid: first window of a line (centre col 1)
- win_eof  out  1  with win_valid: last window of frame (centre row IMG_H-2, col IMG_W-2)

Behaviour:
- Reset (rst_n=0 at edge): col=0, row=0, pix1..pix9=0, win_valid/win_sol/win_eof=0. Line buffer contents not cleared; validity is gated by row count.
- Accept: edge with in_valid=1. If in_valid=0: all state and outputs hold, except win_valid/win_sol/win_eof, which drop to 0 (single-cycle strobes per accepted pixel).
- Line buffers: lb_top and lb_mid, depth IMG_W, asynchronous read, addressed by col. On accept:
  - rd_top = lb_top[col], rd_mid = lb_mid[col]
  - lb_top[col] ← rd_mid
  - lb_mid[col] ← in_pix
  - Read-before-write at the same address.
- Window shift on accept:
  - pix1←pix2, pix2←pix3, pix3←rd_top
  - pix4←pix5, pix5←pix6, pix6←rd_mid
  - pix7←pix8, pix8←pix9, pix9←in_pix
- Latency: one clock. Outputs reflect the pixel accepted at the previous edge.
- Flags (registered with the shift; use pre-increment col/row of the accepted pixel):
  - win_valid = (row≥2 && col≥2)
  - win_sol = win_valid && col==2
  - win_eof = win_valid && row==IMG_H-1 && col==IMG_W-1
- Counters: col increments per accept and wraps IMG_W-1→0, then row increments. Row wraps IMG_H-1→0 after the last pixel.
- Border: no windows are emitted for border centres (no padding). A frame yields exactly (IMG_W-2)*(IMG_H-2) win_valid pulses. Windows never straddle a line wrap, because col≥2 is required.
- in_sof with in_valid:
  - The pixel is treated as (0,0) regardless of counters.
  - Counters are forced so the next pixel is (0,1).
  - No window is emitted for this pixel.
  - Mid-frame in_sof aborts the old frame silently.
- in_sof without in_valid is ignored.
- Reset mid-frame: next accepted pixel is (0,0). No stale window is emitted until two new lines are filled.
- Counter widths: $clog2(IMG_W), $clog2(IMG_H). Compare against IMG_W-1 and IMG_H-1 exactly; no out-of-range values.

Decomposition:
- Package win_pkg holds:
  - PIX_W default
  - typedef pix_t
  - WIN_N=9 constant
  - win_t struct/array of 9 pix_t with index↔pixN mapping
- One sub-module, line_buf: depth/width parameterised, async read, sync write, single address (read-old). Instantiated twice.
- Counters, shift registers and flags stay in win_gen_3x3.

Test Plan:
- IMG_W=4, IMG_H=4, in_pix=16*row+col, in_sof on first pixel, continuous valid:
  - exactly 4 win_valid pulses
  - first one cycle after pixel 0x22, with pix1..pix9 = 00,01,02,10,11,12,20,21,22
  - win_sol on 1st and 3rd pulses; win_eof on 4th (pix9=0x33)
- Same frame with in_valid low on alternate cycles: identical window sequence, win_valid only in cycles after accepts, outputs hold during gaps.
- Two back-to-back frames: second frame's first window (pix9=0x22) has no contamination from frame-1 lines; row wrap without in_sof works identically.
- rst_n=0 for one cycle after pixel 0x21 of frame 1, then a full new frame: all outputs 0 during reset, then exactly 4 windows matching the ramp.
- in_sof asserted at pixel (2,1) of frame 1: no window for that pixel; subsequent data is treated as a new frame and yields 4 correct windows.
- IMG_W=8, IMG_H=5, random pixels: windows match a software 3x3 extraction; 18 pulses; one win_eof.
